cam_alloc: RTL

//  Ternary content-addressable memory with per-entry valid bits, automatic free-entry allocation,

---
 rtl/cam_alloc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cam_alloc.sv
// Ternary CAM with valid bits, free-entry allocation, invalidate and round-robin victims.
// Define CAM_ALLOC_REG_OUT_EN to register the match/multi/raddr search results.
module cam_alloc #(
   parameter  int DATA  = 32,
   parameter  int DEPTH = 32,
   parameter  int WRITE = 2,
   parameter  int READ  = 2,
   parameter  int INV   = 1,
   localparam int ADDR  = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WRITE-1:0]        we_,
   input  logic [WRITE-1:0]        walloc,
   input  logic [WRITE*ADDR-1:0]   waddr,
   input  logic [WRITE*DATA-1:0]   wm,
   input  logic [WRITE*DATA-1:0]   wd,
   output logic [WRITE*ADDR-1:0]   wslot,
   input  logic [INV-1:0]          inv_,
   input  logic [INV*ADDR-1:0]     iaddr,
   input  logic [READ-1:0]         re_,
   input  logic [READ*DATA-1:0]    rm,
   input  logic [READ*DATA-1:0]    rd,
   output logic [READ-1:0]         match,
   output logic [READ-1:0]         multi,
   output logic [READ*ADDR-1:0]    raddr,
   output logic [ADDR:0]           count,
   output logic                    full,
   output logic                    empty
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DATA-1:0]  data_q [DEPTH];
   logic [DATA-1:0]  mask_q [DEPTH];
   logic [ADDR-1:0]  rp_q, rp_d;
   logic [ADDR:0]    count_q, count_d;
   logic             full_q, empty_q;

   logic [WRITE-1:0] wen;
   logic [ADDR-1:0]  slot [WRITE];
   logic [DEPTH-1:0] free;
   logic [ADDR-1:0]  nvict;
   logic             found;

   logic [READ-1:0]      m_c, mu_c;
   logic [READ*ADDR-1:0] ra_c;
   logic                 hit;

   // Resolve each port's target: explicit address, lowest free entry, or next victim.
   always_comb begin
      wen   = ~we_;
      free  = ~valid_q;
      nvict = '0;
      found = 1'b0;
      wslot = '0;
      for (int p = 0; p < WRITE; p++) begin
         if (wen[p] && !walloc[p]) begin
            free[waddr[p*ADDR +: ADDR]] = 1'b0;
         end
      end
      for (int p = 0; p < WRITE; p++) begin
         slot[p] = waddr[p*ADDR +: ADDR];
         if (wen[p] && walloc[p]) begin
            found = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (!found && free[e]) begin
                  slot[p] = ADDR'(e);
                  found   = 1'b1;
               end
            end
            if (found) begin
               free[slot[p]] = 1'b0;
            end else begin
               slot[p] = rp_q + nvict;
               nvict   = nvict + 1'b1;
            end
         end
         if (wen[p]) begin
            wslot[p*ADDR +: ADDR] = slot[p];
         end
      end
      rp_d = rp_q + nvict;
   end

   // Next valid bits: invalidates first so a same-cycle write wins.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < INV; i++) begin
         if (!inv_[i]) begin
            valid_d[iaddr[i*ADDR +: ADDR]] = 1'b0;
         end
      end
      for (int p = 0; p < WRITE; p++) begin
         if (wen[p]) begin
            valid_d[slot[p]] = 1'b1;
         end
      end
      count_d = '0;
      for (int e = 0; e < DEPTH; e++) begin
         count_d = count_d + (ADDR+1)'(valid_d[e]);
      end
   end

   // Valid bits, replacement pointer and occupancy flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         rp_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         valid_q <= valid_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         full_q  <= (count_d == (ADDR+1)'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Entry payload; later ports overwrite earlier ones on a shared target.
   always_ff @(posedge clk) begin
      for (int p = 0; p < WRITE; p++) begin
         if (wen[p] && !reset) begin
            data_q[slot[p]] <= wd[p*DATA +: DATA];
            mask_q[slot[p]] <= wm[p*DATA +: DATA];
         end
      end
   end

   // Masked search of pre-edge state, lowest matching index wins.
   always_comb begin
      m_c  = '0;
      mu_c = '0;
      ra_c = '0;
      hit  = 1'b0;
      for (int r = 0; r < READ; r++) begin
         for (int e = 0; e < DEPTH; e++) begin
            hit = valid_q[e] &&
                  (((data_q[e] ^ rd[r*DATA +: DATA]) &
                    ~mask_q[e] & ~rm[r*DATA +: DATA]) == '0);
            if (!re_[r] && hit) begin
               if (m_c[r]) begin
                  mu_c[r] = 1'b1;
               end else begin
                  m_c[r] = 1'b1;
                  ra_c[r*ADDR +: ADDR] = ADDR'(e);
               end
            end
         end
      end
   end

`ifdef CAM_ALLOC_REG_OUT_EN
   logic [READ-1:0]      match_q, multi_q;
   logic [READ*ADDR-1:0] raddr_q;

   // Search results held for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_q <= '0;
         multi_q <= '0;
         raddr_q <= '0;
      end else begin
         match_q <= m_c;
         multi_q <= mu_c;
         raddr_q <= ra_c;
      end
   end

   assign match = match_q;
   assign multi = multi_q;
   assign raddr = raddr_q;
`else
   assign match = m_c;
   assign multi = mu_c;
   assign raddr = ra_c;
`endif

   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule
